// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory-subsystem types and constants
//   arb_state_e  : arbiter ownership states (IDLE / OWN_I / OWN_D)
//   MEM_READY    : DRAM status meaning "beat complete / ready"
//   MEM_BUSY     : DRAM status meaning "busy"; also what a non-owner sees
//   BURST_BEATS  : beats per 64-byte cache line on an 8-byte bus
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} arb_state_e;
  localparam logic [1:0] MEM_READY = 2'b00;
  localparam logic [1:0] MEM_BUSY = 2'b01;
  localparam int BURST_BEATS = 8;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one DRAM port between I-cache and D-cache
//   clk, rst_n                         : clock, async active-low reset
//   i_addr, i_rd_ctrl / i_dout, i_state : instruction-cache request / response
//   d_addr, d_din, d_rd_ctrl, d_wr_ctrl / d_dout, d_state : data-cache request / response
//   mem_addr, mem_din, mem_rd_ctrl, mem_wr_ctrl / mem_dout, mem_state : DRAM controller side
//   grant                               : one-hot owner, bit0 = I, bit1 = D
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST_BEATS = mem_arbiter_pkg::BURST_BEATS,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_rd_ctrl,
  output logic [ADDR_W-1:0] i_dout,
  output logic [1:0]        i_state,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_din,
  input  logic [2:0]        d_rd_ctrl,
  input  logic [2:0]        d_wr_ctrl,
  output logic [ADDR_W-1:0] d_dout,
  output logic [1:0]        d_state,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_din,
  output logic [2:0]        mem_rd_ctrl,
  output logic [2:0]        mem_wr_ctrl,
  input  logic [ADDR_W-1:0] mem_dout,
  input  logic [1:0]        mem_state,
  output logic [1:0]        grant
);
  localparam int CW = BURST_BEATS > 1 ? $clog2(BURST_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_BEATS - 1);
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // last_owner: 0 = I, 1 = D
  logic last_d_q, last_d_d;
  logic i_req, d_req, own_i, own_d, own_req, beat, release_own;
  assign i_req = |i_rd_ctrl;
  assign d_req = (|d_rd_ctrl) || (|d_wr_ctrl);
  assign own_i = state_q == OWN_I;
  assign own_d = state_q == OWN_D;
  assign own_req = own_i ? i_req : own_d ? d_req : 1'b0;
  assign beat = own_req && mem_state == MEM_READY;
  // dropping ctrl ends the tenure early (uncached single access)
  assign release_own = !own_req || (beat && cnt_q == LAST_BEAT);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d_d = last_d_q;
    if (state_q == IDLE)
      state_d = (i_req && d_req) ? (last_d_q ? OWN_I : OWN_D) : i_req ? OWN_I : d_req ? OWN_D : IDLE;
    else if (release_own) begin
      state_d = IDLE;
      cnt_d = '0;
      last_d_d = own_d;
    end else if (beat)
      cnt_d = cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_d_q <= last_d_d;
    end
  end
  assign mem_addr = own_i ? i_addr : own_d ? d_addr : '0;
  assign mem_din = own_d ? d_din : '0;
  assign mem_rd_ctrl = own_i ? i_rd_ctrl : own_d ? d_rd_ctrl : 3'b000;
  assign mem_wr_ctrl = own_d ? d_wr_ctrl : 3'b000;
  assign i_dout = own_i ? mem_dout : '0;
  assign i_state = own_i ? mem_state : MEM_BUSY;
  assign d_dout = own_d ? mem_dout : '0;
  assign d_state = own_d ? mem_state : MEM_BUSY;
  assign grant = {own_d, own_i};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int BB = 8;
  localparam int AW = 64;
  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] i_addr, i_dout, d_addr, d_din, d_dout, mem_addr, mem_din, mem_dout;
  logic [2:0] i_rd_ctrl, d_rd_ctrl, d_wr_ctrl, mem_rd_ctrl, mem_wr_ctrl;
  logic [1:0] i_state, d_state, mem_state, grant;
  int n_cmp = 0;
  int n_err = 0;
  int own = 0;
  int beats = 0;
  int last = 1;
  int wait_i;
  bit i_on, d_on;
  always #5 clk = ~clk;
  mem_arbiter #(.BURST_BEATS(BB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rd_ctrl(i_rd_ctrl), .i_dout(i_dout), .i_state(i_state),
    .d_addr(d_addr), .d_din(d_din), .d_rd_ctrl(d_rd_ctrl), .d_wr_ctrl(d_wr_ctrl),
    .d_dout(d_dout), .d_state(d_state),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
    .mem_dout(mem_dout), .mem_state(mem_state), .grant(grant)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    own = 0;
    beats = 0;
    last = 1;
  endtask
  // own: 0 = nobody, 1 = I, 2 = D; beats counts completed beats of the current tenure
  task automatic model_step();
    bit ir, dr, req;
    ir = |i_rd_ctrl;
    dr = (|d_rd_ctrl) || (|d_wr_ctrl);
    if (own == 0) own = (ir && dr) ? (last == 2 ? 1 : 2) : ir ? 1 : dr ? 2 : 0;
    else begin
      req = own == 1 ? ir : dr;
      if (req && mem_state == 2'b00) beats++;
      if (!req || beats == BB) begin
        last = own;
        own = 0;
        beats = 0;
      end
    end
  endtask
  task automatic check_outputs();
    #1;
    chk("grant", 64'(grant), own == 1 ? 64'd1 : own == 2 ? 64'd2 : 64'd0);
    chk("mem_addr", mem_addr, own == 1 ? i_addr : own == 2 ? d_addr : 64'd0);
    chk("mem_din", mem_din, own == 2 ? d_din : 64'd0);
    chk("mem_rd_ctrl", 64'(mem_rd_ctrl), own == 1 ? 64'(i_rd_ctrl) : own == 2 ? 64'(d_rd_ctrl) : 64'd0);
    chk("mem_wr_ctrl", 64'(mem_wr_ctrl), own == 2 ? 64'(d_wr_ctrl) : 64'd0);
    chk("i_dout", i_dout, own == 1 ? mem_dout : 64'd0);
    chk("i_state", 64'(i_state), own == 1 ? 64'(mem_state) : 64'd1);
    chk("d_dout", d_dout, own == 2 ? mem_dout : 64'd0);
    chk("d_state", 64'(d_state), own == 2 ? 64'(mem_state) : 64'd1);
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic rand_inputs();
    int mode;
    if ($urandom_range(0, 19) == 0) i_on = !i_on;
    if ($urandom_range(0, 19) == 0) d_on = !d_on;
    i_rd_ctrl = i_on ? 3'($urandom_range(1, 7)) : 3'b000;
    mode = $urandom_range(0, 2);
    d_rd_ctrl = (d_on && mode != 1) ? 3'($urandom_range(1, 7)) : 3'b000;
    d_wr_ctrl = (d_on && mode != 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    mem_state = $urandom_range(0, 9) < 7 ? 2'b00 : 2'($urandom_range(1, 3));
    i_addr = {$urandom, $urandom};
    d_addr = {$urandom, $urandom};
    d_din = {$urandom, $urandom};
    mem_dout = {$urandom, $urandom};
  endtask
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    model_reset();
    check_outputs();
    chk("async_rst_grant", 64'(grant), 64'd0);
    chk("async_rst_mem_rd", 64'(mem_rd_ctrl), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    i_addr = 64'h1000; d_addr = 64'h2000; d_din = 64'hDEAD_BEEF_0000_0001; mem_dout = 64'h55;
    i_rd_ctrl = 3'b000; d_rd_ctrl = 3'b000; d_wr_ctrl = 3'b000; mem_state = 2'b00;
    #2;
    check_outputs();
    chk("rst_grant", 64'(grant), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    i_rd_ctrl = 3'b001;
    d_rd_ctrl = 3'b110;
    check_outputs();
    wait_i = 1;
    for (int k = 0; k < 40 && grant != 2'b01; k++) begin
      step();
      check_outputs();
      if (k == 0) chk("tie_grant_d", 64'(grant), 64'd2);
      if (grant != 2'b01) wait_i++;
    end
    chk("i_wait_cycles", 64'(wait_i), 64'(BB + 2));
    d_rd_ctrl = 3'b000;
    repeat (5) begin
      step();
      check_outputs();
    end
    reset_pulse();
    i_on = 1'b1;
    d_on = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      rand_inputs();
      check_outputs();
      if (c % 700 == 350) reset_pulse();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_BEATS, default 8: beats per cache-line burst (64-byte line / 8-byte bus).
REQ-002 Parameter ADDR_W, default 64: address and data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_addr  input  ADDR_W  instruction-cache request address.
REQ-006 i_rd_ctrl  input  3  instruction-cache read control; nonzero = request.
REQ-007 i_dout  output  ADDR_W  read data to instruction cache.
REQ-008 i_state  output  2  memory status to instruction cache; 2'b00 = beat complete.
REQ-009 d_addr  input  ADDR_W  data-cache request address.
REQ-010 d_din  input  ADDR_W  data-cache write data.
REQ-011 d_rd_ctrl, d_wr_ctrl  input  3 each  data-cache read/write control; either nonzero = request.
REQ-012 d_dout  output  ADDR_W  read data to data cache.
REQ-013 d_state  output  2  memory status to data cache, same encoding as i_state.
REQ-014 mem_addr, mem_din  output  ADDR_W  address and write data to the DRAM controller.
REQ-015 mem_rd_ctrl, mem_wr_ctrl  output  3 each  controls to the DRAM controller.
REQ-016 mem_dout  input  ADDR_W  DRAM read data.
REQ-017 mem_state  input  2  DRAM controller status; 2'b00 = beat complete/ready.
REQ-018 grant  output  2  one-hot owner: bit0 = I, bit1 = D, 2'b00 = no owner.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, OWN_I, OWN_D.
REQ-020 In IDLE, all mem_* outputs SHALL be 0, both *_dout SHALL be 0, both *_state SHALL be 2'b01, and grant SHALL be 2'b00.
REQ-021 From IDLE with one requester active, the FSM SHALL enter that requester's OWN state on the next edge (1-cycle grant latency).
REQ-022 From IDLE with both active, the FSM SHALL grant the requester that is not last_owner (round-robin).
REQ-023 In OWN_X, the owner's addr/din/ctrl SHALL drive mem_* combinationally, unmodified, including simultaneous nonzero d_rd_ctrl and d_wr_ctrl.
REQ-024 In OWN_X, X_dout SHALL equal mem_dout and X_state SHALL equal mem_state.
REQ-025 In OWN_X, the non-owner SHALL see dout 0 and state 2'b01.
REQ-026 The beat counter (width $clog2(BURST_BEATS)) SHALL increment on each OWN_X cycle where mem_state == 2'b00 and X's ctrl is nonzero.
REQ-027 OWN_X SHALL return to IDLE on the next edge when X's ctrl is all-zero (early release, e.g. uncached single access) or when a beat completes with counter == BURST_BEATS-1.
REQ-028 On that release, counter SHALL clear and last_owner SHALL be set to X.
REQ-029 There SHALL be no direct OWN_I to OWN_D transition; one IDLE cycle always separates owners.
REQ-030 A non-owner's request arriving mid-burst SHALL wait, and is served no later than the first grant after the current burst.
REQ-031 Maximum wait SHALL be one burst plus 2 cycles, assuming the DRAM controller makes progress.

Reset
REQ-032 Asserting rst_n low SHALL immediately force IDLE, counter 0, last_owner = I, and all outputs to their REQ-020 values, including mid-burst.
REQ-033 After rst_n deasserts, the first tie SHALL grant D.

Structure
REQ-034 The state enum (IDLE/OWN_I/OWN_D), the mem_state encodings (READY = 2'b00, BUSY = 2'b01), and BURST_BEATS SHALL live in the shared memory-subsystem package.
REQ-035 There SHALL be no sub-module; the output mux and FSM are a single module (~150 lines).

Verification
REQ-036 Single D read burst: d_rd_ctrl = 3'b110, mem_state READY every cycle -> grant = 2'b10 one cycle after request, 8 beats, IDLE on the following edge.
REQ-037 Simultaneous I and D after reset -> D is granted first; I is granted after D releases plus one IDLE cycle; I waits one burst plus 2 cycles.
REQ-038 I request arriving at D beat 3 -> i_state holds 2'b01 and i_dout holds 0 until D completes all 8 beats; mem_addr never shows i_addr during OWN_D.
REQ-039 D write burst, d_wr_ctrl = 3'b100, d_din = 64'hDEAD_BEEF_0000_0001 -> mem_wr_ctrl = 3'b100 and mem_din equals d_din each cycle; mem_state = 2'b01 stalls suppress counter increment.
REQ-040 Early release: D drops its ctrl after 1 beat -> IDLE on the next edge, counter 0, last_owner = D.
REQ-041 rst_n pulsed low at I beat 5 -> grant = 2'b00 and mem_rd_ctrl = 0 asynchronously; after release, a new I request restarts at beat 0.
